mem_arbiter: RTL

Shares one single-port unified memory between the pipeline's instruction-fetch stage (IF) and its data-memory stage (MEM). The arbiter grants one access at a time, sequences the fixed memory read latency and returns data to the granted requester. It drives per-port stall signals that the CPU uses to hold the PC and the pipeline registers while a request is pending.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} arb_port_t;

  localparam int unsigned LAT_MIN = 1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data (MEM).
// One access is granted at a time, the fixed read latency is sequenced and the
// read word is returned to the granted port with a one-cycle valid pulse.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   if_req/if_addr    - fetch request; if_rdata/if_valid fetch response
//   d_req/d_wr/d_addr/d_wdata - data request; d_rdata/d_valid data response
//   stall_if/stall_mem - combinational pipeline hold signals
//   m_en/m_we/m_addr/m_wdata - memory strobe (combinational, grant cycle)
//   m_rdata           - memory read data, valid LAT cycles after m_en
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int unsigned CW = $clog2(LAT + 1);

  if (LAT < LAT_MIN) begin : g_lat_check
    $error("mem_arbiter: LAT must be at least %0d", LAT_MIN);
  end

  arb_state_t    r_state, w_state_nxt;
  arb_port_t     r_owner, w_owner_nxt;
  arb_port_t     r_last,  w_last_nxt;
  arb_port_t     w_gport;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [DW-1:0] r_if_rdata, r_d_rdata;
  logic          r_if_valid, r_d_valid;
  logic          w_if_valid_nxt, w_d_valid_nxt;
  logic          w_if_cap, w_d_cap;
  logic          w_if_elig, w_d_elig;
  logic          w_grant, w_grant_d;

  // Arbitration, latency sequencing and completion decode
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_if_valid_nxt = 1'b0;
    w_d_valid_nxt  = 1'b0;
    w_if_cap       = 1'b0;
    w_d_cap        = 1'b0;
    w_grant        = 1'b0;
    w_grant_d      = 1'b0;
    w_gport        = FETCH;
    // A port in its valid cycle is not eligible, so a held req is not re-granted
    w_if_elig      = if_req & ~r_if_valid;
    w_d_elig       = d_req  & ~r_d_valid;

    case (r_state)
      IDLE: begin
        // Gated by reset so no memory strobe leaks out while held in reset
        if (reset && (w_if_elig || w_d_elig)) begin
          w_grant     = 1'b1;
          w_grant_d   = w_d_elig & (~w_if_elig | (r_last == FETCH));
          w_gport     = w_grant_d ? DATA : FETCH;
          w_owner_nxt = w_gport;
          w_last_nxt  = w_gport;
          if (w_grant_d && d_wr) begin
            // Stores complete without waiting for memory latency
            w_d_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CW'(LAT - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          if (r_owner == DATA) begin
            w_d_cap       = 1'b1;
            w_d_valid_nxt = 1'b1;
          end else begin
            w_if_cap       = 1'b1;
            w_if_valid_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, arbitration history and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner    <= FETCH;
      r_last     <= FETCH;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_d_valid  <= w_d_valid_nxt;
      if (w_if_cap) r_if_rdata <= m_rdata;
      if (w_d_cap)  r_d_rdata  <= m_rdata;
    end
  end

  // Memory strobe and pipeline stalls
  always_comb begin
    m_en      = w_grant;
    m_we      = w_grant_d & d_wr;
    m_addr    = '0;
    m_wdata   = '0;
    if (w_grant) begin
      m_addr  = w_grant_d ? d_addr : if_addr;
      m_wdata = d_wdata;
    end
    stall_if  = reset & if_req & ~r_if_valid;
    stall_mem = reset & d_req  & ~r_d_valid;
  end

  assign if_rdata = r_if_rdata;
  assign if_valid = r_if_valid;
  assign d_rdata  = r_d_rdata;
  assign d_valid  = r_d_valid;

endmodule
